fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter / fetch sequencer for the 9-bit core; consumer end of the decoder's branch_en.
//  Holds the PC and a loadable branch-target LUT, and runs the Start/Done program handshake with the bench.
//  Each RUN cycle advances PC by 1, or jumps to LUT[BranchIdx] when branch_en=1; stops on Halt.
//  PC drives instruction ROM address; Halt/branch_en/BranchIdx come from decode of the current instruction.
// PARAMETERS
//  PC_W        10   PC / instruction ROM address width
//  LUT_AW      4    branch LUT index width (2**LUT_AW entries)
//  START_ADDR  0    PC loaded on every Start
//  CNT_W       16   CycleCount width
// PORTS
//  CLK         in   1        clock, all state updates on posedge
//  Reset       in   1        synchronous, active-low reset
//  Start       in   1        begin program (sampled in IDLE/HALTED only)
//  Halt        in   1        current instruction is halt (valid in RUN)
//  branch_en   in   1        take branch this cycle (from Ctrl)
//  BranchIdx   in   LUT_AW   LUT entry selecting branch target
//  lut_we      in   1        LUT write enable
//  lut_addr    in   LUT_AW   LUT write index
//  lut_data    in   PC_W     LUT write data (absolute target)
//  PC          out  PC_W     current fetch address
//  Running     out  1        1 while in RUN
//  Done        out  1        1 while in HALTED
//  CycleCount  out  CNT_W    RUN cycles since last Start
// BEHAVIOUR
//  Reset (Reset==0 at posedge): state=IDLE, PC=0, Running=0, Done=0, CycleCount=0, all LUT entries=0.
//  Reset dominates every other input; reset mid-RUN aborts program, no Done pulse.
//  States: IDLE, RUN, HALTED. Running/Done are registered decodes of state (Running=RUN, Done=HALTED).
//  IDLE:   Start=1 -> PC<=START_ADDR, CycleCount<=0, state<=RUN. Else hold.
//  RUN (priority order, evaluated each posedge):
//   1. Halt=1 -> state<=HALTED, PC holds (points at halt instr); branch_en ignored.
//   2. branch_en=1 -> PC<=LUT[BranchIdx].
//   3. else PC<=PC+1, modulo 2**PC_W (all-ones wraps to 0, no flag).
//   CycleCount +1 every RUN posedge incl. the halting one; saturates at all-ones.
//   Start ignored in RUN.
//  HALTED: Done=1 held indefinitely; PC, CycleCount hold. Start=1 -> same actions as IDLE Start
//   (Done drops the cycle after, Running rises the same cycle).
//  Branch latency: target visible on PC one cycle after branch_en sampled; no delay slot.
//  LUT write: synchronous, takes effect next cycle; accepted only in IDLE/HALTED, silently dropped
//   in RUN. Write and Start in same cycle: both performed (LUT not read until RUN).
//  LUT read: combinational on BranchIdx; out-of-range impossible (full 2**LUT_AW array).
//  No X-propagation allowed: unknown Halt/branch_en only matter in RUN.
// TESTING
//  1. Reset low 2 cycles then high, no Start -> PC=0, Running=0, Done=0 held 10 cycles.
//  2. Start pulse, no branch/halt 5 cycles -> PC 0,1,2,3,4,5; Running=1; CycleCount=5.
//  3. Write LUT[3]=0x120 in IDLE, Start, at PC=2 branch_en=1 BranchIdx=3 -> next PC=0x120, then 0x121.
//  4. Halt and branch_en both 1 at PC=7 -> PC stays 7, Done=1 next cycle; lut_we in RUN
//     to LUT[3]=0x050 earlier leaves LUT[3]=0x120.
//  5. PC_W=10, PC=0x3FF no branch -> PC=0x000; Start in HALTED -> PC=START_ADDR, CycleCount=0, Done=0.
//  6. Reset low mid-RUN at PC=0x40 -> next cycle PC=0, IDLE, Done=0, LUT[3] reads 0.

Source files
------------

// File: rtl/fetch_if.sv
// Fetch sequencer bus: program handshake, decode inputs, LUT load port and
// the PC/status outputs. master = bench/core side, slave = fetch_unit.
interface fetch_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 16
);
    logic              Start;
    logic              Halt;
    logic              branch_en;
    logic [LUT_AW-1:0] BranchIdx;
    logic              lut_we;
    logic [LUT_AW-1:0] lut_addr;
    logic [PC_W-1:0]   lut_data;
    logic [PC_W-1:0]   PC;
    logic              Running;
    logic              Done;
    logic [CNT_W-1:0]  CycleCount;

    modport master (
        output Start, Halt, branch_en, BranchIdx, lut_we, lut_addr, lut_data,
        input  PC, Running, Done, CycleCount
    );

    modport slave (
        input  Start, Halt, branch_en, BranchIdx, lut_we, lut_addr, lut_data,
        output PC, Running, Done, CycleCount
    );
endinterface

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer. Holds the PC and a branch-target LUT and
// runs the Start/Done handshake. In RUN the PC advances by one each cycle, or
// jumps to LUT[BranchIdx] on branch_en, until Halt is seen.
module fetch_unit #(
    parameter int              PC_W       = 10,
    parameter int              LUT_AW     = 4,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              CNT_W      = 16
) (
    input  logic   CLK,
    input  logic   Reset,
    fetch_if.slave bus
);
    localparam int LUT_N = 2 ** LUT_AW;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_running;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [PC_W-1:0]  r_lut [LUT_N];
    logic [PC_W-1:0]  w_target;

    // Branch target is a plain combinational read; the array covers every index.
    assign w_target = r_lut[bus.BranchIdx];

    // Sequencer: state, PC, cycle counter, status flags and LUT writes.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= '0;
            for (int i = 0; i < LUT_N; i++) begin
                r_lut[i] <= '0;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    // Counter includes the halting cycle and sticks at all-ones.
                    if (r_cnt != {CNT_W{1'b1}}) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (bus.Halt) begin
                        // PC stays on the halt instruction; branch_en is ignored.
                        r_state   <= S_HALTED;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (bus.branch_en) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                default: begin
                    // IDLE and HALTED behave alike: LUT is writable, Start launches.
                    // A write issued together with Start still lands, since the
                    // LUT is only read once RUN begins.
                    if (bus.lut_we) begin
                        r_lut[bus.lut_addr] <= bus.lut_data;
                    end
                    if (bus.Start) begin
                        r_state   <= S_RUN;
                        r_pc      <= START_ADDR;
                        r_cnt     <= '0;
                        r_running <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.PC         = r_pc;
    assign bus.Running    = r_running;
    assign bus.Done       = r_done;
    assign bus.CycleCount = r_cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset idle, sequential fetch, branching,
// halt priority, dropped RUN-time LUT writes, PC wrap, restart and mid-run reset.
module tb_fetch_unit;
    localparam int PC_W   = 10;
    localparam int LUT_AW = 4;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    fetch_if #(.PC_W(PC_W), .LUT_AW(LUT_AW), .CNT_W(CNT_W)) fif ();

    fetch_unit #(
        .PC_W      (PC_W),
        .LUT_AW    (LUT_AW),
        .START_ADDR(10'h000),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK  (clk),
        .Reset(rst_n),
        .bus  (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        fif.Start     = 1'b0;
        fif.Halt      = 1'b0;
        fif.branch_en = 1'b0;
        fif.BranchIdx = '0;
        fif.lut_we    = 1'b0;
        fif.lut_addr  = '0;
        fif.lut_data  = '0;

        // 1. reset then idle with no Start
        tick();
        tick();
        chk("rst_pc", 32'(fif.PC), 32'h0);
        chk("rst_running", 32'(fif.Running), 32'h0);
        chk("rst_done", 32'(fif.Done), 32'h0);
        chk("rst_cnt", 32'(fif.CycleCount), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_pc", 32'(fif.PC), 32'h0);
            chk("idle_running", 32'(fif.Running), 32'h0);
            chk("idle_done", 32'(fif.Done), 32'h0);
        end

        // 2. sequential fetch
        fif.Start = 1'b1;
        tick();
        fif.Start = 1'b0;
        chk("start_pc", 32'(fif.PC), 32'h0);
        chk("start_running", 32'(fif.Running), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", 32'(fif.PC), 32'(i));
        end
        chk("seq_cnt", 32'(fif.CycleCount), 32'd5);
        chk("seq_running", 32'(fif.Running), 32'h1);
        // Start is ignored while running
        fif.Start = 1'b1;
        tick();
        fif.Start = 1'b0;
        chk("run_start_pc", 32'(fif.PC), 32'h6);
        chk("run_start_cnt", 32'(fif.CycleCount), 32'd6);
        fif.Halt = 1'b1;
        tick();
        fif.Halt = 1'b0;
        chk("halt1_pc", 32'(fif.PC), 32'h6);
        chk("halt1_done", 32'(fif.Done), 32'h1);
        chk("halt1_running", 32'(fif.Running), 32'h0);
        chk("halt1_cnt", 32'(fif.CycleCount), 32'd7);

        // 3. LUT write together with Start, then branch
        fif.lut_we   = 1'b1;
        fif.lut_addr = 4'd3;
        fif.lut_data = 10'h120;
        fif.Start    = 1'b1;
        tick();
        fif.lut_we = 1'b0;
        fif.Start  = 1'b0;
        chk("restart_pc", 32'(fif.PC), 32'h0);
        chk("restart_cnt", 32'(fif.CycleCount), 32'h0);
        chk("restart_running", 32'(fif.Running), 32'h1);
        chk("restart_done", 32'(fif.Done), 32'h0);
        tick();
        tick();
        chk("pre_br_pc", 32'(fif.PC), 32'h2);
        fif.branch_en = 1'b1;
        fif.BranchIdx = 4'd3;
        fif.lut_we    = 1'b1;       // dropped: RUN-time write
        fif.lut_addr  = 4'd3;
        fif.lut_data  = 10'h050;
        tick();
        fif.branch_en = 1'b0;
        fif.lut_we    = 1'b0;
        chk("br_pc", 32'(fif.PC), 32'h120);
        tick();
        chk("br_next_pc", 32'(fif.PC), 32'h121);
        fif.branch_en = 1'b1;
        tick();
        fif.branch_en = 1'b0;
        chk("lut_kept_pc", 32'(fif.PC), 32'h120);
        fif.Halt = 1'b1;
        tick();
        fif.Halt = 1'b0;
        chk("halt2_pc", 32'(fif.PC), 32'h120);
        chk("halt2_cnt", 32'(fif.CycleCount), 32'd6);

        // LUT[5]=0x3FF written in HALTED without Start; state holds
        fif.lut_we   = 1'b1;
        fif.lut_addr = 4'd5;
        fif.lut_data = 10'h3FF;
        tick();
        fif.lut_we = 1'b0;
        chk("halted_hold_done", 32'(fif.Done), 32'h1);
        chk("halted_hold_pc", 32'(fif.PC), 32'h120);

        // 4. Halt and branch_en together at PC=7
        fif.Start = 1'b1;
        tick();
        fif.Start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("pc7", 32'(fif.PC), 32'h7);
        fif.Halt      = 1'b1;
        fif.branch_en = 1'b1;
        fif.BranchIdx = 4'd5;
        tick();
        fif.Halt      = 1'b0;
        fif.branch_en = 1'b0;
        chk("halt_pri_pc", 32'(fif.PC), 32'h7);
        chk("halt_pri_done", 32'(fif.Done), 32'h1);
        chk("halt_pri_running", 32'(fif.Running), 32'h0);
        chk("halt_pri_cnt", 32'(fif.CycleCount), 32'd8);

        // 5. PC wrap 0x3FF -> 0x000
        fif.Start = 1'b1;
        tick();
        fif.Start = 1'b0;
        fif.branch_en = 1'b1;
        fif.BranchIdx = 4'd5;
        tick();
        fif.branch_en = 1'b0;
        chk("wrap_pre_pc", 32'(fif.PC), 32'h3FF);
        tick();
        chk("wrap_pc", 32'(fif.PC), 32'h000);
        fif.Halt = 1'b1;
        tick();
        fif.Halt = 1'b0;
        chk("halt3_done", 32'(fif.Done), 32'h1);
        chk("halt3_cnt", 32'(fif.CycleCount), 32'd3);
        fif.lut_we   = 1'b1;
        fif.lut_addr = 4'd6;
        fif.lut_data = 10'h03E;
        tick();
        fif.lut_we = 1'b0;
        fif.Start  = 1'b1;
        tick();
        fif.Start = 1'b0;
        chk("halted_start_pc", 32'(fif.PC), 32'h0);
        chk("halted_start_cnt", 32'(fif.CycleCount), 32'h0);
        chk("halted_start_done", 32'(fif.Done), 32'h0);

        // 6. reset mid-RUN at PC=0x40
        fif.branch_en = 1'b1;
        fif.BranchIdx = 4'd6;
        tick();
        fif.branch_en = 1'b0;
        tick();
        tick();
        chk("pc40", 32'(fif.PC), 32'h040);
        rst_n = 1'b0;
        tick();
        chk("midrst_pc", 32'(fif.PC), 32'h0);
        chk("midrst_running", 32'(fif.Running), 32'h0);
        chk("midrst_done", 32'(fif.Done), 32'h0);
        chk("midrst_cnt", 32'(fif.CycleCount), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", 32'(fif.Done), 32'h0);
        fif.Start = 1'b1;
        tick();
        fif.Start = 1'b0;
        chk("post_rst_running", 32'(fif.Running), 32'h1);
        tick();
        tick();
        fif.branch_en = 1'b1;
        fif.BranchIdx = 4'd3;
        tick();
        fif.branch_en = 1'b0;
        chk("lut_cleared_pc", 32'(fif.PC), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
